// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the D-MEM boot loader.
// Frame: header, 16-bit LE word count, count*4 LE data bytes, 8-bit additive checksum.
package boot_loader_pkg;

    localparam logic [7:0] BOOT_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } boot_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } boot_err_t;

    // The checksum covers the count bytes and the data bytes, modulo 256.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Assembles little-endian bytes into words; the finished word is copied to a holding
// register so a new byte0 can arrive in the same cycle the word is presented.
module boot_word_asm
    import boot_loader_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic [1:0]      byte_idx,
    output logic [BITS-1:0] word,
    output logic            word_ready
);

    logic [BITS-1:0] asm_q;
    logic [BITS-1:0] asm_next;

    always_comb begin
        asm_next = asm_q;
        asm_next[byte_idx*8 +: 8] = byte_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= 2'd0;
            asm_q      <= '0;
            word       <= '0;
            word_ready <= 1'b0;
        end else if (clear) begin
            byte_idx   <= 2'd0;
            asm_q      <= '0;
            word       <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
                asm_q    <= asm_next;
                if (byte_idx == 2'd3) begin
                    word       <= asm_next;
                    word_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot-write side of D-MEM: parses the UART byte stream and writes the image,
// holding bootloading high until a checksum-valid image has been written.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int BITS           = 32,
    parameter int ADDRW          = 15,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             boot_req,
    output logic [BITS-1:0]  wdata_data,
    output logic [ADDRW-1:0] wdata_addr,
    output logic             we_boot,
    output logic             bootloading,
    output logic             boot_done,
    output logic [1:0]       boot_err,
    output logic [15:0]      words_loaded,
    output boot_state_t      state_dbg
);

    localparam int              TW        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_WORDS = 17'((2 ** (ADDRW - 2)) - BASE_ADDR / 4);
    localparam logic [ADDRW-1:0] BASE     = ADDRW'(BASE_ADDR);

    boot_state_t      state_q;
    boot_err_t        err_q;
    logic [ADDRW-1:0] addr_q;
    logic [15:0]      words_q;
    logic [15:0]      count_q;
    logic [7:0]       count_lo_q;
    logic [7:0]       csum_q;
    logic [TW-1:0]    tmo_q;

    logic        restart;
    logic        header_hit;
    logic        in_frame;
    logic        tmo_hit;
    logic [16:0] count_in;
    logic [1:0]  byte_idx;
    logic        word_ready;

    // rx_valid is a single-cycle strobe with no back-pressure: a byte is consumed in
    // exactly the cycle its strobe is high, so the parser must accept one every cycle.
    assign restart    = boot_req && (state_q == DONE || state_q == ERR);
    assign header_hit = (state_q == SYNC) && rx_valid && (rx_data == BOOT_HEADER);
    assign in_frame   = (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == CHECK);
    assign tmo_hit    = (tmo_q == TMO_LAST);
    assign count_in   = {1'b0, rx_data, count_lo_q};

    boot_word_asm #(.BITS(BITS)) u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (restart || header_hit),
        .byte_valid(rx_valid && (state_q == DATA)),
        .byte_data (rx_data),
        .byte_idx  (byte_idx),
        .word      (wdata_data),
        .word_ready(word_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SYNC;
            err_q      <= ERR_NONE;
            addr_q     <= BASE;
            words_q    <= 16'd0;
            count_q    <= 16'd0;
            count_lo_q <= 8'd0;
            csum_q     <= 8'd0;
            tmo_q      <= '0;
        end else if (restart) begin
            state_q    <= SYNC;
            err_q      <= ERR_NONE;
            addr_q     <= BASE;
            words_q    <= 16'd0;
            count_q    <= 16'd0;
            count_lo_q <= 8'd0;
            csum_q     <= 8'd0;
            tmo_q      <= '0;
        end else begin
            if (word_ready) begin
                addr_q  <= addr_q + ADDRW'(4);
                words_q <= words_q + 16'd1;
            end
            if (in_frame && !rx_valid) tmo_q <= tmo_q + 1'b1;
            else                       tmo_q <= '0;

            case (state_q)
                SYNC: begin
                    if (header_hit) begin
                        state_q <= LEN0;
                        csum_q  <= 8'd0;
                    end
                end
                LEN0: begin
                    if (rx_valid) begin
                        count_lo_q <= rx_data;
                        csum_q     <= csum_add(csum_q, rx_data);
                        state_q    <= LEN1;
                    end else if (tmo_hit) begin
                        state_q <= ERR;
                        err_q   <= ERR_TIMEOUT;
                    end
                end
                LEN1: begin
                    if (rx_valid) begin
                        count_q <= count_in[15:0];
                        csum_q  <= csum_add(csum_q, rx_data);
                        if (count_in == 17'd0) begin
                            state_q <= CHECK;
                        end else if (count_in > MAX_WORDS) begin
                            state_q <= ERR;
                            err_q   <= ERR_LEN;
                        end else begin
                            state_q <= DATA;
                        end
                    end else if (tmo_hit) begin
                        state_q <= ERR;
                        err_q   <= ERR_TIMEOUT;
                    end
                end
                DATA: begin
                    // Leave DATA on the last byte itself so a checksum byte arriving
                    // during the final write strobe is not taken as data.
                    if (rx_valid) begin
                        csum_q <= csum_add(csum_q, rx_data);
                        if (byte_idx == 2'd3 && (words_q + 16'd1) == count_q)
                            state_q <= CHECK;
                    end else if (tmo_hit) begin
                        state_q <= ERR;
                        err_q   <= ERR_TIMEOUT;
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == csum_q) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= ERR;
                            err_q   <= ERR_CSUM;
                        end
                    end else if (tmo_hit) begin
                        state_q <= ERR;
                        err_q   <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign we_boot      = word_ready;
    assign wdata_addr   = addr_q;
    assign words_loaded = words_q;
    assign boot_err     = err_q;
    assign bootloading  = (state_q != DONE);
    assign boot_done    = (state_q == DONE);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: hand-built frames, expected writes queued up front
// and matched against every we_boot pulse.
module tb_boot_loader;
    import boot_loader_pkg::*;

    localparam int BITS  = 32;
    localparam int ADDRW = 15;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic [7:0]       rx_data  = 8'h00;
    logic             rx_valid = 1'b0;
    logic             boot_req = 1'b0;
    logic [BITS-1:0]  wdata_data;
    logic [ADDRW-1:0] wdata_addr;
    logic             we_boot;
    logic             bootloading;
    logic             boot_done;
    logic [1:0]       boot_err;
    logic [15:0]      words_loaded;
    boot_state_t      state_dbg;

    boot_loader #(
        .BITS(BITS), .ADDRW(ADDRW), .BASE_ADDR(0), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .boot_req(boot_req), .wdata_data(wdata_data), .wdata_addr(wdata_addr),
        .we_boot(we_boot), .bootloading(bootloading), .boot_done(boot_done),
        .boot_err(boot_err), .words_loaded(words_loaded), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    logic [46:0] exp_q[$];
    int          we_cyc[$];
    logic [7:0]  frame_q[$];
    logic [46:0] mon_e;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && we_boot) begin
            we_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("we_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("we_addr", 64'(wdata_addr), 64'(mon_e[46:32]));
                check("we_data", 64'(wdata_data), 64'(mon_e[31:0]));
            end
        end
    end

    // driver tasks (called at a falling edge, return at a falling edge)
    task automatic expect_write(input logic [14:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap, input int lat_idx);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i]);
            if (i == lat_idx) check("lat_we", 64'(we_boot), 1);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_boot_req();
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bootloading"}, 64'(bootloading), 1);
        check({tag, "_done"}, 64'(boot_done), 0);
        check({tag, "_err"}, 64'(boot_err), 0);
        check({tag, "_addr"}, 64'(wdata_addr), 0);
        check({tag, "_data"}, 64'(wdata_data), 0);
        check({tag, "_words"}, 64'(words_loaded), 0);
        check({tag, "_we"}, 64'(we_boot), 0);
        check({tag, "_state"}, 64'(state_dbg), 64'(SYNC));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // two-word image, spaced bytes, latency checked on the first word
        expect_write(15'h0000, 32'h12345678);
        expect_write(15'h0004, 32'hDEADBEEF);
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4E};
        send_frame(2, 6);
        check("t1_done", 64'(boot_done), 1);
        check("t1_bootloading", 64'(bootloading), 0);
        check("t1_words", 64'(words_loaded), 2);
        check("t1_err", 64'(boot_err), 0);
        check("t1_addr", 64'(wdata_addr), 8);
        check("t1_q", 64'(exp_q.size()), 0);
        send_byte(8'hA5);
        repeat (2) @(negedge clk);
        check("t1_done_ignores_rx", 64'(state_dbg), 64'(DONE));

        // bad checksum: writes still happen, then error 1; restart recovers
        pulse_boot_req();
        check_idle("t2_restart");
        expect_write(15'h0000, 32'h12345678);
        expect_write(15'h0004, 32'hDEADBEEF);
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4F};
        send_frame(2, -1);
        check("t2_err", 64'(boot_err), 1);
        check("t2_bootloading", 64'(bootloading), 1);
        check("t2_done", 64'(boot_done), 0);
        check("t2_q", 64'(exp_q.size()), 0);
        pulse_boot_req();
        check("t2_err_cleared", 64'(boot_err), 0);
        expect_write(15'h0000, 32'h12345678);
        expect_write(15'h0004, 32'hDEADBEEF);
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4E};
        send_frame(1, -1);
        check("t2_retry_done", 64'(boot_done), 1);

        // leading garbage is ignored in SYNC
        pulse_boot_req();
        expect_write(15'h0000, 32'h00000001);
        frame_q = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h00,
                    8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        send_frame(1, -1);
        check("t3_done", 64'(boot_done), 1);
        check("t3_words", 64'(words_loaded), 1);
        check("t3_q", 64'(exp_q.size()), 0);

        // boot_req with a coincident header in DONE: the byte is dropped
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        boot_req = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        boot_req = 1'b0;
        check("req_wins_state", 64'(state_dbg), 64'(SYNC));
        check("req_wins_done", 64'(boot_done), 0);

        // length overflow
        frame_q = '{8'hA5, 8'hFF, 8'hFF};
        send_frame(1, -1);
        repeat (4) @(negedge clk);
        check("t4_err", 64'(boot_err), 2);
        check("t4_state", 64'(state_dbg), 64'(ERR));
        check("t4_bootloading", 64'(bootloading), 1);

        // timeout 100 cycles after the last strobe
        pulse_boot_req();
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'hAA};
        send_frame(0, -1);
        repeat (99) @(negedge clk);
        check("t5_not_yet", 64'(boot_err), 0);
        @(negedge clk);
        check("t5_err", 64'(boot_err), 3);
        check("t5_state", 64'(state_dbg), 64'(ERR));

        // zero-length image
        pulse_boot_req();
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(1, -1);
        check("t6_done", 64'(boot_done), 1);
        check("t6_words", 64'(words_loaded), 0);

        // continuous stream, three words: checksum = 3 + (1+..+12) = 0x51
        pulse_boot_req();
        expect_write(15'h0000, 32'h04030201);
        expect_write(15'h0004, 32'h08070605);
        expect_write(15'h0008, 32'h0C0B0A09);
        we_cyc.delete();
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                    8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h51};
        send_frame(0, 6);
        repeat (3) @(negedge clk);
        check("t7_done", 64'(boot_done), 1);
        check("t7_words", 64'(words_loaded), 3);
        check("t7_nwrites", 64'(we_cyc.size()), 3);
        if (we_cyc.size() == 3) begin
            check("t7_gap1", 64'(we_cyc[1] - we_cyc[0]), 4);
            check("t7_gap2", 64'(we_cyc[2] - we_cyc[1]), 4);
        end
        check("t7_q", 64'(exp_q.size()), 0);

        // asynchronous reset in the middle of the second word
        pulse_boot_req();
        expect_write(15'h0000, 32'h12345678);
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAA, 8'hBB};
        send_frame(0, -1);
        check("t8_words_pre", 64'(words_loaded), 1);
        #2 rst_n = 1'b0;
        #1 check_idle("t8_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_write(15'h0000, 32'h00000001);
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        send_frame(1, -1);
        check("t8_done", 64'(boot_done), 1);

        // final report
        check("end_q", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
